// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter for a shared SDRAM: each access slot goes to chip DMA, refresh or one of
// four round-robin requesters; a watchdog reclaims slots whose access never reports done.
module sdram_slot_arbiter #(
    parameter int REFRESH_INTERVAL = 890,
    parameter int WATCHDOG         = 63
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       slot_strobe,
    input  logic       chip_slot,
    input  logic       chip_req,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       grant_chip,
    output logic       refresh_go,
    output logic       busy,
    output logic       slot_miss,
    output logic       wd_err,
    output logic [1:0] dbg_state
);

    localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int WW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_INTERVAL - 1);
    localparam logic [RW-1:0] REF_ONE    = RW'(1);
    localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG - 1);
    localparam logic [WW-1:0] WD_ONE     = WW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHIP    = 2'd1,
        S_REQ     = 2'd2,
        S_REFRESH = 2'd3
    } state_t;

    state_t        r_state;
    logic [1:0]    r_rr;
    logic          r_ref_pend;
    logic [RW-1:0] r_ref_cnt;
    logic [WW-1:0] r_wd_cnt;

    logic       w_ref_expire;
    logic       w_found;
    logic [1:0] w_winner;

    assign w_ref_expire = (r_ref_cnt == '0);
    assign dbg_state    = r_state;

    // Round-robin pick: first set req bit at or above r_rr, wrapping mod 4.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && req[r_rr + 2'(i)]) begin
                w_found  = 1'b1;
                w_winner = r_rr + 2'(i);
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr       <= 2'd0;
            r_ref_pend <= 1'b0;
            r_ref_cnt  <= REF_RELOAD;
            r_wd_cnt   <= '0;
            grant      <= 4'b0000;
            grant_chip <= 1'b0;
            refresh_go <= 1'b0;
            busy       <= 1'b0;
            slot_miss  <= 1'b0;
            wd_err     <= 1'b0;
        end else begin
            slot_miss <= 1'b0;
            wd_err    <= 1'b0;
            r_ref_cnt <= w_ref_expire ? REF_RELOAD : (r_ref_cnt - REF_ONE);

            case (r_state)
                S_IDLE: begin
                    if (slot_strobe) begin
                        r_wd_cnt <= '0;
                        if (chip_slot && chip_req) begin
                            r_state    <= S_CHIP;
                            grant_chip <= 1'b1;
                            busy       <= 1'b1;
                        end else if (r_ref_pend) begin
                            r_state    <= S_REFRESH;
                            refresh_go <= 1'b1;
                            busy       <= 1'b1;
                            r_ref_pend <= 1'b0;
                        end else if (w_found) begin
                            r_state <= S_REQ;
                            grant   <= 4'b0001 << w_winner;
                            busy    <= 1'b1;
                            r_rr    <= w_winner + 2'd1;
                        end
                    end
                end
                default: begin
                    // A strobe during any grant, even one closed by done this cycle, is lost.
                    slot_miss <= slot_strobe;
                    if (done || (r_wd_cnt == WD_LAST)) begin
                        r_state    <= S_IDLE;
                        grant      <= 4'b0000;
                        grant_chip <= 1'b0;
                        refresh_go <= 1'b0;
                        busy       <= 1'b0;
                        if (!done) begin
                            wd_err <= 1'b1;
                            if (r_state == S_REFRESH) r_ref_pend <= 1'b1;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_ONE;
                    end
                end
            endcase

            // A fresh expiry wins over the clear on refresh entry so it is not dropped.
            if (w_ref_expire) r_ref_pend <= 1'b1;
        end
    end

endmodule
